// File: rtl/uart_transmitter.sv
// uart_transmitter: serial UART transmitter.
// A frame is one start bit, DATA_WIDTH data bits sent LSB first, an optional
// parity bit and STOP_BITS stop bits. Every bit lasts 16 tick pulses.
// Ports:
//   clk      - clock
//   arst     - asynchronous active-high reset
//   tick     - 16x oversampling enable, one clk wide
//   tx_start - request to send data_in (ignored while tx_busy)
//   data_in  - payload word
//   tx       - serial line, idle high
//   tx_busy  - high while a frame is in progress
//   tx_done  - one-clk pulse at end of frame
module uart_transmitter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              tick_cnt_q, tick_cnt_d;
  logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    parity_q, parity_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end;

  // Last tick of the current bit period.
  assign bit_end = tick && (tick_cnt_q == 4'd15);

  // State and output registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // 4-bit counter wraps 15->0 by itself at each bit boundary.
    if (state_q != IDLE && tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        tick_cnt_d = 4'd0;
        if (tx_start) begin
          shift_d    = data_in;
          parity_d   = (^data_in) ^ 1'(PARITY_ODD);
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter: three instances (default framing, even
// parity with two stop bits, odd parity) share the stimulus. Each one is
// compared every clk against a frame-level model: a frame is a bit array,
// and the line shows element (ticks_elapsed / 16).
module tb_uart_transmitter;

  localparam int PEN [3] = '{0, 1, 1};
  localparam int POD [3] = '{0, 0, 1};
  localparam int SB  [3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       arst;
  logic       tick;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx_w   [3];
  logic       busy_w [3];
  logic       done_w [3];

  int n_tests = 0;
  int n_fail  = 0;
  int tmode;
  int ph;

  // Reference model state.
  bit active [3];
  int pos    [3];
  bit fbits  [3][12];
  int flen   [3];
  bit edone  [3];
  int busy_cnt [3];
  int done_cnt [3];

  always #5 clk = ~clk;

  uart_transmitter #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .arst(arst), .tick(tick), .tx_start(tx_start), .data_in(data_in),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_transmitter #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .arst(arst), .tick(tick), .tx_start(tx_start), .data_in(data_in),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_transmitter #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .arst(arst), .tick(tick), .tx_start(tx_start), .data_in(data_in),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int m);
    active[m] = 1'b0;
    pos[m]    = 0;
    edone[m]  = 1'b0;
  endtask

  task automatic model_start(input int m, input logic [7:0] d);
    int n;
    fbits[m][0] = 1'b0;
    for (int i = 0; i < 8; i++) fbits[m][1+i] = d[i];
    n = 9;
    if (PEN[m] != 0) begin
      fbits[m][n] = (^d) ^ (POD[m] != 0);
      n++;
    end
    for (int s = 0; s < SB[m]; s++) begin
      fbits[m][n] = 1'b1;
      n++;
    end
    flen[m]   = n;
    active[m] = 1'b1;
    pos[m]    = 0;
  endtask

  task automatic model_step(input int m);
    if (arst) begin
      model_reset(m);
    end else begin
      edone[m] = 1'b0;
      if (!active[m]) begin
        if (tx_start) model_start(m, data_in);
      end else if (tick) begin
        pos[m]++;
        if (pos[m] == flen[m] * 16) begin
          active[m] = 1'b0;
          edone[m]  = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input int m);
    logic etx;
    etx = active[m] ? fbits[m][pos[m] / 16] : 1'b1;
    chk($sformatf("tx[%0d] pos=%0d", m, pos[m]), 32'(tx_w[m]), 32'(etx));
    chk($sformatf("busy[%0d]", m), 32'(busy_w[m]), 32'(active[m]));
    chk($sformatf("done[%0d]", m), 32'(done_w[m]), 32'(edone[m]));
  endtask

  task automatic clear_cnt();
    for (int m = 0; m < 3; m++) begin
      busy_cnt[m] = 0;
      done_cnt[m] = 0;
    end
  endtask

  // One clk: drive tick, update model at the edge, check at the falling edge.
  task automatic cyc();
    if (tmode == 0) tick = 1'($urandom_range(0, 1));
    else            tick = ((ph % tmode) == 0);
    @(posedge clk);
    for (int m = 0; m < 3; m++) model_step(m);
    ph++;
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      check(m);
      busy_cnt[m] += int'(busy_w[m]);
      done_cnt[m] += int'(done_w[m]);
    end
  endtask

  task automatic pulse_start(input logic [7:0] d);
    data_in  = d;
    tx_start = 1'b1;
    ph       = 0;
    cyc();
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((active[0] || active[1] || active[2]) && n < bound) begin
      cyc();
      n++;
    end
    chk("idle_timeout", 32'(n < bound), 32'd1);
  endtask

  initial begin
    arst = 1'b1; tx_start = 1'b0; data_in = 8'h00; tick = 1'b0;
    tmode = 1; ph = 0;
    for (int m = 0; m < 3; m++) model_reset(m);
    clear_cnt();
    repeat (3) cyc();
    arst = 1'b0;
    repeat (5) cyc();

    // 0xA5, tick every clk.
    clear_cnt();
    tmode = 1;
    pulse_start(8'hA5);
    repeat (199) cyc();
    chk("s1_busy0", 32'(busy_cnt[0]), 32'd160);
    chk("s1_busy1", 32'(busy_cnt[1]), 32'd192);
    chk("s1_busy2", 32'(busy_cnt[2]), 32'd176);
    chk("s1_done0", 32'(done_cnt[0]), 32'd1);
    chk("s1_done1", 32'(done_cnt[1]), 32'd1);

    // 0x3C, tick every 4th clk.
    clear_cnt();
    tmode = 4;
    pulse_start(8'h3C);
    repeat (799) cyc();
    chk("s2_busy0", 32'(busy_cnt[0]), 32'd640);
    chk("s2_busy1", 32'(busy_cnt[1]), 32'd768);
    chk("s2_done0", 32'(done_cnt[0]), 32'd1);

    // 0x07: even parity bit 1, odd parity bit 0.
    tmode = 1;
    pulse_start(8'h07);
    repeat (152) cyc();
    chk("s3_par_even", 32'(tx_w[1]), 32'd1);
    chk("s3_par_odd", 32'(tx_w[2]), 32'd0);
    wait_idle(400);

    // 0xFF, random ticks, tx_start re-pulsed mid-frame.
    clear_cnt();
    tmode = 0;
    pulse_start(8'hFF);
    for (int k = 1; k <= 100; k++) begin
      tx_start = (k % 15 == 0);
      data_in  = 8'($urandom);
      cyc();
    end
    tx_start = 1'b0;
    wait_idle(2000);
    for (int m = 0; m < 3; m++) chk($sformatf("s4_done%0d", m), 32'(done_cnt[m]), 32'd1);

    // tx_start held high: back-to-back frames, data_in changing mid-frame.
    clear_cnt();
    tmode = 1;
    tx_start = 1'b1;
    for (int j = 0; j < 600; j++) begin
      data_in = 8'($urandom);
      cyc();
    end
    tx_start = 1'b0;
    wait_idle(400);
    for (int m = 0; m < 3; m++) chk($sformatf("s5_done%0d", m), 32'(done_cnt[m]), 32'd4);

    // Reset during data bit 3, then a clean 0x55 frame.
    pulse_start(8'h5A);
    repeat (70) cyc();
    arst = 1'b1;
    for (int m = 0; m < 3; m++) model_reset(m);
    #1;
    for (int m = 0; m < 3; m++) check(m);
    repeat (2) cyc();
    arst = 1'b0;
    repeat (20) begin
      data_in = 8'($urandom);
      cyc();
    end
    clear_cnt();
    pulse_start(8'h55);
    wait_idle(400);
    for (int m = 0; m < 3; m++) chk($sformatf("s6_done%0d", m), 32'(done_cnt[m]), 32'd1);

    // Random payloads with random tick spacing.
    tmode = 0;
    repeat (6) begin
      pulse_start(8'($urandom));
      repeat ($urandom_range(0, 5)) cyc();
      wait_idle(3000);
      repeat ($urandom_range(0, 3)) cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
